// File: rtl/dpram_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// dpram_fifo_ctrl
//
// Synchronous FIFO controller placed directly in front of a dual-port RAM.
// It owns the RAM address and write-enable lines; all data storage is in the
// RAM. Port A writes (push side), port B reads (pop side).
//
// Handshake semantics: a push is accepted on a rising edge when
// wr_en=1 and full=0; a pop is accepted when rd_en=1 and empty=0. Both use
// the flags of the current cycle, which are decoded from the registered count
// only. A rejected request has no effect other than setting the sticky
// overflow/underflow flag. rd_valid=1 marks the cycle after an accepted pop,
// when rd_data carries the popped word; otherwise rd_data holds its value.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   wr_en, wr_data      push request and data
//   rd_en               pop request
//   clr_err             synchronous clear of overflow/underflow
//   rd_data, rd_valid   registered popped word and its valid strobe
//   full, empty         count == MEM_LENGTH / count == 0
//   almost_full         count >= AFULL_THRESH
//   almost_empty        count <= AEMPTY_THRESH
//   count               occupancy 0..MEM_LENGTH
//   overflow/underflow  sticky error flags
//   ram_wen_a, ram_waddr_a, ram_wdata_a   RAM port A (write)
//   ram_wen_b, ram_raddr_b, ram_rdata_b   RAM port B (read, async data)
// -----------------------------------------------------------------------------
module dpram_fifo_ctrl #(
    parameter int DATA_WIDTH    = 8,
    parameter int MEM_LENGTH    = 64,
    parameter int AFULL_THRESH  = 56,
    parameter int AEMPTY_THRESH = 8,
    localparam int AW           = $clog2(MEM_LENGTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic                  clr_err,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [AW:0]           count,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  ram_wen_a,
    output logic [AW-1:0]         ram_waddr_a,
    output logic [DATA_WIDTH-1:0] ram_wdata_a,
    output logic                  ram_wen_b,
    output logic [AW-1:0]         ram_raddr_b,
    input  logic [DATA_WIDTH-1:0] ram_rdata_b
);

    localparam logic [AW:0]   DEPTH_C  = (AW+1)'(MEM_LENGTH);
    localparam logic [AW:0]   AFULL_C  = (AW+1)'(AFULL_THRESH);
    localparam logic [AW:0]   AEMPTY_C = (AW+1)'(AEMPTY_THRESH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    // Flags come from the registered count only, never from pointer
    // equality, so wrapped pointers cannot alias full with empty.
    assign full         = (count == DEPTH_C);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AFULL_C);
    assign almost_empty = (count <= AEMPTY_C);

    // When full, a simultaneous pop does not make room for the push, and
    // when empty there is no fall-through: each side looks only at its own
    // current-cycle flag.
    assign push = wr_en & ~full;
    assign pop  = rd_en & ~empty;

    assign ram_wen_a   = push;
    assign ram_waddr_a = wr_ptr;
    assign ram_wdata_a = wr_data;
    assign ram_wen_b   = 1'b0;
    assign ram_raddr_b = rd_ptr;

    // Pointers and occupancy. Pointers wrap naturally because MEM_LENGTH is
    // a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Read data path: one cycle of latency from pop to rd_valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= pop;
            if (pop) begin
                rd_data <= ram_rdata_b;
            end
        end
    end

    // Sticky errors: a new error in the same cycle as clr_err keeps the flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= (wr_en & full)  | (overflow  & ~clr_err);
            underflow <= (rd_en & empty) | (underflow & ~clr_err);
        end
    end

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dpram_fifo_ctrl
//
// Bench for dpram_fifo_ctrl. Holds a behavioural RAM on the DUT's RAM ports,
// a queue-based model of the FIFO, a per-cycle compare process on the falling
// edge, directed sequences with literal expectations, and a random phase.
// -----------------------------------------------------------------------------
module tb_dpram_fifo_ctrl;

    localparam int DW    = 8;
    localparam int DEPTH = 64;
    localparam int AW    = 6;
    localparam int AF_T  = 56;
    localparam int AE_T  = 8;

    // ---------------- clock / reset / DUT signals ----------------
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          rd_en;
    logic          clr_err;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [AW:0]   count;
    logic          overflow;
    logic          underflow;
    logic          ram_wen_a;
    logic [AW-1:0] ram_waddr_a;
    logic [DW-1:0] ram_wdata_a;
    logic          ram_wen_b;
    logic [AW-1:0] ram_raddr_b;
    logic [DW-1:0] ram_rdata_b;

    always #5 clk = ~clk;

    dpram_fifo_ctrl #(
        .DATA_WIDTH    (DW),
        .MEM_LENGTH    (DEPTH),
        .AFULL_THRESH  (AF_T),
        .AEMPTY_THRESH (AE_T)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .clr_err      (clr_err),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow),
        .ram_wen_a    (ram_wen_a),
        .ram_waddr_a  (ram_waddr_a),
        .ram_wdata_a  (ram_wdata_a),
        .ram_wen_b    (ram_wen_b),
        .ram_raddr_b  (ram_raddr_b),
        .ram_rdata_b  (ram_rdata_b)
    );

    // ---------------- behavioural dual-port RAM ----------------
    logic [DW-1:0] mem [DEPTH];

    always @(posedge clk) begin
        if (ram_wen_a === 1'b1) begin
            mem[ram_waddr_a] <= ram_wdata_a;
        end
    end
    assign ram_rdata_b = mem[ram_raddr_b];

    // ---------------- scoreboard / reference model ----------------
    int checks = 0;
    int errors = 0;

    logic [DW-1:0] exp_q[$];
    logic          m_rd_valid;
    logic [DW-1:0] m_rd_data;
    logic          m_ovf;
    logic          m_udf;
    int unsigned   n_push;
    int unsigned   n_pop;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: occupancy is the queue size; RAM addresses are the number of
    // accepted pushes/pops since reset, modulo the depth.
    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                exp_q.delete();
                m_rd_valid = 1'b0;
                m_rd_data  = '0;
                m_ovf      = 1'b0;
                m_udf      = 1'b0;
                n_push     = 0;
                n_pop      = 0;
            end else begin
                int  sz;
                bit  do_push;
                bit  do_pop;
                sz      = exp_q.size();
                do_push = (wr_en === 1'b1) && (sz < DEPTH);
                do_pop  = (rd_en === 1'b1) && (sz > 0);
                m_rd_valid = do_pop;
                if (do_pop) begin
                    m_rd_data = exp_q.pop_front();
                    n_pop++;
                end
                if (do_push) begin
                    exp_q.push_back(wr_data);
                    n_push++;
                end
                if (wr_en === 1'b1 && sz == DEPTH) m_ovf = 1'b1;
                else if (clr_err === 1'b1)         m_ovf = 1'b0;
                if (rd_en === 1'b1 && sz == 0)     m_udf = 1'b1;
                else if (clr_err === 1'b1)         m_udf = 1'b0;
            end
        end
    end

    // Compare every output against the model on each falling edge.
    always @(negedge clk) begin
        int sz;
        sz = exp_q.size();
        chk("count",        32'(count),        32'(sz));
        chk("full",         32'(full),         32'(sz == DEPTH));
        chk("empty",        32'(empty),        32'(sz == 0));
        chk("almost_full",  32'(almost_full),  32'(sz >= AF_T));
        chk("almost_empty", 32'(almost_empty), 32'(sz <= AE_T));
        chk("rd_valid",     32'(rd_valid),     32'(m_rd_valid));
        chk("rd_data",      32'(rd_data),      32'(m_rd_data));
        chk("overflow",     32'(overflow),     32'(m_ovf));
        chk("underflow",    32'(underflow),    32'(m_udf));
        chk("ram_wen_a",    32'(ram_wen_a),    32'(rst && wr_en && sz < DEPTH));
        chk("ram_waddr_a",  32'(ram_waddr_a),  n_push % DEPTH);
        chk("ram_wdata_a",  32'(ram_wdata_a),  32'(wr_data));
        chk("ram_wen_b",    32'(ram_wen_b),    32'd0);
        chk("ram_raddr_b",  32'(ram_raddr_b),  n_pop % DEPTH);
    end

    // ---------------- driver tasks ----------------
    // Inputs change 1 time unit after a falling edge; the task returns just
    // after the next falling edge, so the rising edge in between consumed them.
    task automatic drive(input logic we, input logic [DW-1:0] wd, input logic re, input logic ce);
        wr_en   = we;
        wr_data = wd;
        rd_en   = re;
        clr_err = ce;
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        wr_en = 1'b0; wr_data = '0; rd_en = 1'b0; clr_err = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        #1;
        rst = 1'b1;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not end, errors so far %0d", errors);
        $fatal(1, "timeout");
    end

    // ---------------- main sequence ----------------
    logic [DW-1:0] vals [4];
    logic [AW-1:0] saved_raddr;
    logic [AW-1:0] prev_waddr;
    bit            seen_wrap;

    initial begin
        wr_en = 1'b0; wr_data = '0; rd_en = 1'b0; clr_err = 1'b0;
        #1;
        do_reset();

        // Reset then idle
        for (int i = 0; i < 3; i++) begin
            idle();
            chk("idle_count",    32'(count),        32'd0);
            chk("idle_empty",    32'(empty),        32'd1);
            chk("idle_aempty",   32'(almost_empty), 32'd1);
            chk("idle_rd_valid", 32'(rd_valid),     32'd0);
            chk("idle_wen_a",    32'(ram_wen_a),    32'd0);
            chk("idle_wen_b",    32'(ram_wen_b),    32'd0);
        end

        // Push then pop
        vals[0] = 8'd42; vals[1] = 8'd84; vals[2] = 8'd126; vals[3] = 8'd168;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, vals[i], 1'b0, 1'b0);
            chk("pp_push_count", 32'(count), 32'(i + 1));
        end
        for (int i = 0; i < 4; i++) begin
            chk("pp_ram_word", 32'(mem[i]), 32'(vals[i]));
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, '0, 1'b1, 1'b0);
            chk("pp_rd_valid",   32'(rd_valid), 32'd1);
            chk("pp_rd_data",    32'(rd_data),  32'(vals[i]));
            chk("pp_pop_count",  32'(count),    32'(3 - i));
        end
        idle();
        chk("pp_final_empty", 32'(empty),    32'd1);
        chk("pp_final_valid", 32'(rd_valid), 32'd0);

        // Fill to full, overflow, clear
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, DW'(i), 1'b0, 1'b0);
            chk("fill_count",  32'(count),       32'(i + 1));
            chk("fill_afull",  32'(almost_full), 32'((i + 1) >= 56));
            chk("fill_full",   32'(full),        32'((i + 1) == 64));
        end
        drive(1'b1, 8'hEE, 1'b0, 1'b0);
        chk("ovf_flag",  32'(overflow),  32'd1);
        chk("ovf_count", 32'(count),     32'd64);
        chk("ovf_wen_a", 32'(ram_wen_a), 32'd0);
        drive(1'b0, '0, 1'b0, 1'b1);
        chk("ovf_clear", 32'(overflow),  32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b0, '0, 1'b1, 1'b0);
            chk("fill_drain_data", 32'(rd_data), 32'(i));
        end
        idle();

        // Pop when empty, then simultaneous push/pop on empty
        saved_raddr = ram_raddr_b;
        drive(1'b0, '0, 1'b1, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0);
        chk("udf_flag",     32'(underflow),   32'd1);
        chk("udf_rd_valid", 32'(rd_valid),    32'd0);
        chk("udf_raddr",    32'(ram_raddr_b), 32'(saved_raddr));
        drive(1'b1, 8'h5A, 1'b1, 1'b0);
        chk("nofall_count", 32'(count),    32'd1);
        chk("nofall_valid", 32'(rd_valid), 32'd0);
        drive(1'b0, '0, 1'b1, 1'b1);
        chk("nofall_data",  32'(rd_data),   32'h5A);
        chk("udf_cleared",  32'(underflow), 32'd0);

        // Wrap-around
        for (int i = 0; i < 40; i++) drive(1'b1, DW'($urandom_range(0, 255)), 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) drive(1'b0, '0, 1'b1, 1'b0);
        seen_wrap  = 1'b0;
        prev_waddr = ram_waddr_a;
        for (int i = 0; i < 40; i++) begin
            drive(1'b1, DW'(100 + i), 1'b0, 1'b0);
            if (prev_waddr == 6'd63 && ram_waddr_a == 6'd0) seen_wrap = 1'b1;
            prev_waddr = ram_waddr_a;
        end
        chk("wrap_seen", 32'(seen_wrap), 32'd1);
        for (int i = 0; i < 40; i++) begin
            drive(1'b0, '0, 1'b1, 1'b0);
            chk("wrap_data", 32'(rd_data), 32'(100 + i));
        end
        idle();

        // Concurrent push/pop at count 10
        for (int i = 0; i < 10; i++) drive(1'b1, DW'(200 + i), 1'b0, 1'b0);
        for (int k = 0; k < 20; k++) begin
            drive(1'b1, DW'(k), 1'b1, 1'b0);
            chk("conc_count", 32'(count),   32'd10);
            chk("conc_data",  32'(rd_data), (k < 10) ? 32'(200 + k) : 32'(k - 10));
        end
        for (int k = 0; k < 10; k++) begin
            drive(1'b0, '0, 1'b1, 1'b0);
            chk("conc_drain", 32'(rd_data), 32'(10 + k));
        end

        // Concurrent push/pop when full
        for (int i = 0; i < DEPTH; i++) drive(1'b1, DW'(i), 1'b0, 1'b0);
        drive(1'b1, 8'hAA, 1'b1, 1'b0);
        chk("fullboth_count", 32'(count),    32'd63);
        chk("fullboth_ovf",   32'(overflow), 32'd1);
        chk("fullboth_valid", 32'(rd_valid), 32'd1);
        chk("fullboth_data",  32'(rd_data),  32'd0);
        drive(1'b0, '0, 1'b0, 1'b1);
        for (int i = 1; i < DEPTH; i++) begin
            drive(1'b0, '0, 1'b1, 1'b0);
            chk("fullboth_drain", 32'(rd_data), 32'(i));
        end
        idle();

        // Reset mid-operation with a read in flight
        for (int i = 0; i < 31; i++) drive(1'b1, DW'(i), 1'b0, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0);
        chk("pre_rst_count", 32'(count),    32'd30);
        chk("pre_rst_valid", 32'(rd_valid), 32'd1);
        wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_count", 32'(count),    32'd0);
        chk("async_rst_valid", 32'(rd_valid), 32'd0);
        chk("async_rst_empty", 32'(empty),    32'd1);
        @(negedge clk);
        #1;
        rst = 1'b1;
        idle();

        // Randomized traffic in phases with different fill bias
        for (int p = 0; p < 4; p++) begin
            int wr_pct;
            int rd_pct;
            wr_pct = (p == 0) ? 80 : (p == 1) ? 20 : 50;
            rd_pct = (p == 0) ? 20 : (p == 1) ? 80 : 50;
            for (int c = 0; c < 500; c++) begin
                drive(($urandom_range(0, 99) < wr_pct),
                      DW'($urandom_range(0, 255)),
                      ($urandom_range(0, 99) < rd_pct),
                      ($urandom_range(0, 15) == 0));
            end
        end
        idle();
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dpram_fifo_ctrl.md
Name: dpram_fifo_ctrl

Overview:
- Synchronous FIFO controller that sits directly upstream of the dual-port RAM and owns its address and write-enable ports.
- Port A of the RAM is used only for writes (push side). Port B is used only for reads (pop side).
- Provides write/read handshakes, occupancy count, full/empty and almost-full/almost-empty flags, and sticky overflow/underflow error flags.
- Stores no data itself; all storage is in the RAM.

Parameters:
- DATA_WIDTH, 8, data word width; matches the RAM.
- MEM_LENGTH, 64, RAM depth in words; must be a power of 2, minimum 4.
- AFULL_THRESH, 56, almost_full asserts when count >= this value.
- AEMPTY_THRESH, 8, almost_empty asserts when count <= this value.
- Derived, not overridable: AW = $clog2(MEM_LENGTH).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous active-low reset.
- wr_en  in  1  push request.
- wr_data  in  DATA_WIDTH  push data.
- rd_en  in  1  pop request.
- clr_err  in  1  synchronous pulse; clears overflow and underflow.
- rd_data  out  DATA_WIDTH  popped word, registered.
- rd_valid  out  1  rd_data holds a newly popped word this cycle.
- full  out  1  count == MEM_LENGTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AFULL_THRESH.
- almost_empty  out  1  count <= AEMPTY_THRESH.
- count  out  AW+1  current occupancy, 0..MEM_LENGTH.
- overflow  out  1  sticky; a push was attempted while full.
- underflow  out  1  sticky; a pop was attempted while empty.
- ram_wen_a  out  1  RAM port A write enable.
- ram_waddr_a  out  AW  RAM port A write address.
- ram_wdata_a  out  DATA_WIDTH  RAM port A write data.
- ram_wen_b  out  1  tied 0; port B never writes.
- ram_raddr_b  out  AW  RAM port B read address.
- ram_rdata_b  in  DATA_WIDTH  RAM port B read data; combinational with respect to ram_raddr_b.

Behaviour:
- Reset (rst=0, asynchronous):
  - wr_ptr=0, rd_ptr=0, count=0.
  - rd_data=0, rd_valid=0, overflow=0, underflow=0.
  - Resulting flags: empty=1, full=0, almost_empty=1, almost_full=0.
  - RAM contents are not cleared. Stale words are unreachable because the FIFO is empty.
  - Reset mid-operation discards all queued words; an in-flight rd_valid drops immediately.
- Accepted push: push = wr_en & ~full, using full from the current cycle.
  - Combinationally: ram_wen_a=push, ram_waddr_a=wr_ptr, ram_wdata_a=wr_data.
  - At the clock edge: wr_ptr <= wr_ptr+1, wrapping modulo MEM_LENGTH.
- Accepted pop: pop = rd_en & ~empty, using empty from the current cycle.
  - ram_raddr_b=rd_ptr at all times.
  - At the clock edge: rd_data <= ram_rdata_b and rd_ptr <= rd_ptr+1 (wraps).
  - rd_valid is registered: it equals the previous cycle's pop. Read latency is 1 cycle.
  - When rd_valid=0, rd_data holds its last value.
- Count update: push&~pop gives +1; pop&~push gives -1; both or neither gives no change.
- Flags are combinational decodes of the registered count. They never depend on the same-cycle wr_en/rd_en.
- Simultaneous wr_en & rd_en:
  - When empty: only the push is accepted; there is no fall-through. Underflow is set.
  - When full: only the pop is accepted; the push is rejected even though a slot frees this cycle. Overflow is set.
  - Otherwise: both are accepted and count is unchanged.
- Error flags:
  - overflow <= 1 on wr_en & full. underflow <= 1 on rd_en & empty.
  - clr_err clears both at the next edge. A new error event in the same cycle as clr_err wins, and the flag stays 1.
- Rejected requests never change pointers, count, RAM or rd_valid.
- Pointer wrap: after MEM_LENGTH pushes, wr_ptr returns to 0. Full/empty are determined from count only, never from pointer equality.

Test Plan:
- Reset then idle: assert rst=0 for 1 cycle, release, idle 3 cycles -> empty=1, almost_empty=1, count=0, rd_valid=0, ram_wen_a=0, ram_wen_b=0 throughout.
- Push then pop: push 42, 84, 126, 168 on consecutive cycles, then pop 4 cycles -> RAM addresses 0..3 written with those values. rd_valid=1 with rd_data=42, 84, 126, 168 on the 4 cycles following each pop. count steps 1,2,3,4 then 3,2,1,0. Final state empty=1.
- Fill to full: push 64 words (value i at step i) -> almost_full rises when count reaches 56; full=1 at count 64. A 65th wr_en sets overflow=1 with count=64 and ram_wen_a=0. clr_err pulse -> overflow=0.
- Pop when empty: rd_en for 2 cycles on an empty FIFO -> underflow=1, rd_valid=0, rd_ptr unchanged. Simultaneous wr_en=1 with data 0x5A -> count=1, no fall-through.
- Wrap-around: 40 pushes, 40 pops, then 40 more pushes with values 100..139, then pop all -> ram_waddr_a wraps 63->0. Data pops out in order 100..139 with no loss.
- Concurrent push/pop and reset mid-operation:
  - At count=10, drive wr_en and rd_en for 20 cycles -> count stays 10, output order preserved.
  - At count=64, drive both -> pop accepted, push rejected, count=63, overflow=1.
  - Assert rst=0 at count=30 -> count=0 and rd_valid=0 immediately, without waiting for a clock edge.
